// File: rtl/display_pkg.sv
// Shared definitions for the display scan path: blank pattern, scan FSM
// states and the active-low anode decode helper.
package display_pkg;

    // All segments / all anodes off (both are active-low on the board)
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        BLANK,
        ON
    } scan_state_t;

    // Digit d is wired to anode bit 7-d; return the active-low enable for it
    function automatic logic [7:0] anode_onehot_n(input logic [2:0] idx);
        logic [7:0] enables;
        enables = SEG_BLANK;
        enables[3'd7 - idx] = 1'b0;
        return enables;
    endfunction

endpackage

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed scan sequencer for the multi-digit 7-seg display.
// Each digit slot opens with a dead-time blank, then shows the digit with
// PWM brightness and blink gating. New frames are staged in a shadow buffer
// and only copied to the active buffer at the end of the last digit slot.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk_100MHz,
    input  logic                    reset_n,
    input  logic [8*NUM_DIGITS-1:0] frame_data,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [3:0]              brightness,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blink_phase,
    output logic [7:0]              anodes,
    output logic [7:0]              cathodes,
    output logic [2:0]              digit_idx,
    output logic                    frame_start
);

    localparam int SLOT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DWELL_CYCLES - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]        DIGIT_LAST = 3'(NUM_DIGITS - 1);

    scan_state_t             state;
    scan_state_t             next_state;
    logic [SLOT_W-1:0]       slot_cnt;
    logic [3:0]              pwm_cnt;
    logic [8*NUM_DIGITS-1:0] shadow_frame;
    logic [8*NUM_DIGITS-1:0] active_frame;
    logic [63:0]             active_ext;
    logic [7:0]              blink_ext;
    logic                    slot_last;
    logic                    frame_boundary;
    logic [7:0]              anodes_d;
    logic [7:0]              cathodes_d;

    assign slot_last      = (slot_cnt == SLOT_LAST);
    assign frame_boundary = slot_last && (digit_idx == DIGIT_LAST);

    // Pad the frame and blink mask to the full 8-digit width so a 3-bit digit index always selects in range
    always_comb begin
        active_ext = {8{SEG_BLANK}};
        active_ext[8*NUM_DIGITS-1:0] = active_frame;
        blink_ext = '0;
        blink_ext[NUM_DIGITS-1:0] = blink_mask;
    end

    // Slot timer, digit pointer and free-running PWM counter
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (slot_last) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == DIGIT_LAST) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    // Scan state register
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= BLANK;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and pin pattern: blank for the dead time, then the digit gated by PWM and blink
    always_comb begin
        next_state = state;
        anodes_d   = SEG_BLANK;
        cathodes_d = SEG_BLANK;
        case (state)
            BLANK: begin
                if (slot_cnt == BLANK_LAST) begin
                    next_state = ON;
                end
            end
            ON: begin
                cathodes_d = active_ext[{digit_idx, 3'b000} +: 8];
                if ((pwm_cnt <= brightness) && !(blink_ext[digit_idx] && !blink_phase)) begin
                    anodes_d = anode_onehot_n(digit_idx);
                end
                if (slot_last) begin
                    next_state = BLANK;
                end
            end
            default: next_state = BLANK;
        endcase
    end

    // Register the pins so they never glitch; frame_start lines up with the first pin cycle of digit 0
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            anodes      <= SEG_BLANK;
            cathodes    <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            anodes      <= anodes_d;
            cathodes    <= cathodes_d;
            frame_start <= (slot_cnt == '0) && (digit_idx == 3'd0);
        end
    end

    // Frame handshake: accept into the shadow when empty, promote to active only at the frame boundary
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            shadow_frame <= {NUM_DIGITS{SEG_BLANK}};
            active_frame <= {NUM_DIGITS{SEG_BLANK}};
            frame_ready  <= 1'b1;
        end else if (frame_boundary && !frame_ready) begin
            active_frame <= shadow_frame;
            frame_ready  <= 1'b1;
        end else if (frame_valid && frame_ready) begin
            shadow_frame <= frame_data;
            frame_ready  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Self-checking bench for display_scan_scheduler with a short scan
// (4 digits, 20-clock slots, 4-clock blank). Expected pins are derived from
// the number of clocks since reset release plus a frame-level buffer model.
module tb_display_scan_scheduler;

    localparam int NUM_DIGITS = 4;
    localparam int DWELL      = 20;
    localparam int BLANK      = 4;
    localparam int FRAME      = NUM_DIGITS * DWELL;

    logic        clk_100MHz  = 1'b0;
    logic        reset_n     = 1'b1;
    logic [31:0] frame_data  = 32'hFFFF_FFFF;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [3:0]  brightness  = 4'hF;
    logic [3:0]  blink_mask  = 4'b0000;
    logic        blink_phase = 1'b1;
    logic [7:0]  anodes;
    logic [7:0]  cathodes;
    logic [2:0]  digit_idx;
    logic        frame_start;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: clocks since release, displayed frame, staged frame
    int          clocks   = 0;
    logic [31:0] m_active = 32'hFFFF_FFFF;
    logic [31:0] m_shadow = 32'hFFFF_FFFF;
    bit          m_full   = 1'b0;

    always #5 clk_100MHz = ~clk_100MHz;

    display_scan_scheduler #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .brightness (brightness),
        .blink_mask (blink_mask),
        .blink_phase(blink_phase),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .digit_idx  (digit_idx),
        .frame_start(frame_start)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (clock %0d)", tag, got, exp, clocks);
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, " anodes"},      anodes,             8'hFF);
        check_val({tag, " cathodes"},    cathodes,           8'hFF);
        check_val({tag, " digit_idx"},   {5'd0, digit_idx},  8'h00);
        check_val({tag, " frame_ready"}, {7'd0, frame_ready}, 8'h01);
        check_val({tag, " frame_start"}, {7'd0, frame_start}, 8'h00);
    endtask

    task automatic model_reset();
        clocks   = 0;
        m_active = 32'hFFFF_FFFF;
        m_shadow = 32'hFFFF_FFFF;
        m_full   = 1'b0;
    endtask

    // One clock: predict the pins from the pre-edge position in the frame, clock, then compare
    task automatic tick();
        int         pos_in_slot;
        int         dig;
        int         pwm;
        logic [7:0] exp_an;
        logic [7:0] exp_cat;
        logic       exp_fs;
        bit         was_full;
        pos_in_slot = clocks % DWELL;
        dig         = (clocks / DWELL) % NUM_DIGITS;
        pwm         = clocks % 16;
        exp_an      = 8'hFF;
        exp_cat     = 8'hFF;
        if (pos_in_slot >= BLANK) begin
            exp_cat = m_active[dig*8 +: 8];
            if ((pwm <= int'(brightness)) && !(blink_mask[dig] && !blink_phase)) begin
                exp_an[7-dig] = 1'b0;
            end
        end
        exp_fs   = (clocks % FRAME) == 0;
        was_full = m_full;
        if (was_full && (clocks % FRAME) == FRAME - 1) begin
            m_active = m_shadow;
            m_full   = 1'b0;
        end
        if (!was_full && frame_valid) begin
            m_shadow = frame_data;
            m_full   = 1'b1;
        end
        clocks++;
        @(posedge clk_100MHz);
        #1;
        check_val("anodes",      anodes,              exp_an);
        check_val("cathodes",    cathodes,            exp_cat);
        check_val("digit_idx",   {5'd0, digit_idx},   8'((clocks / DWELL) % NUM_DIGITS));
        check_val("frame_start", {7'd0, frame_start}, {7'd0, exp_fs});
        check_val("frame_ready", {7'd0, frame_ready}, {7'd0, !m_full});
    endtask

    // Advance until the next edge is at the given clock position within the frame
    task automatic run_until(input int pos);
        while ((clocks % FRAME) != pos) tick();
    endtask

    initial begin
        // Reset applied asynchronously, checked before any clock edge
        #2 reset_n = 1'b0;
        #1 check_reset("reset async");
        repeat (2) @(posedge clk_100MHz);
        #1 check_reset("reset held");
        reset_n = 1'b1;
        model_reset();

        // Full brightness, first frame accepted immediately
        frame_data  = {8'hC0, 8'hF9, 8'hA4, 8'hB0};
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        repeat (3*FRAME - 1) tick();

        // Reduced brightness levels
        brightness = 4'd3;
        repeat (FRAME) tick();
        brightness = 4'd0;
        repeat (FRAME) tick();
        brightness = 4'd15;

        // Blink digit 1
        blink_mask  = 4'b0010;
        blink_phase = 1'b0;
        repeat (FRAME) tick();
        blink_phase = 1'b1;
        repeat (FRAME) tick();
        blink_mask  = 4'b0000;

        // Mid-frame offer, then a second frame held through ready=0
        run_until(30);
        frame_data  = 32'h8292_F8B0;
        frame_valid = 1'b1;
        tick();
        frame_data  = 32'h9988_C6A1;
        run_until(0);
        tick();
        frame_valid = 1'b0;
        repeat (2*FRAME) tick();

        // Offer exactly on the boundary clock while the shadow is full
        run_until(10);
        frame_data  = 32'h1234_5678;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        run_until(FRAME - 1);
        frame_data  = 32'hA5C3_0F96;
        frame_valid = 1'b1;
        tick();
        tick();
        frame_valid = 1'b0;
        repeat (2*FRAME) tick();

        // Randomized brightness, blink and frame traffic
        repeat (6*FRAME) begin
            if ($urandom_range(0, 9) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) blink_phase = ~blink_phase;
            if (!frame_valid && $urandom_range(0, 29) == 0) begin
                frame_data  = $urandom;
                frame_valid = 1'b1;
            end else if (frame_valid && $urandom_range(0, 2) == 0) begin
                frame_valid = 1'b0;
            end
            tick();
        end

        // Reset during digit 2 ON with a frame pending in the shadow
        brightness  = 4'd15;
        blink_mask  = 4'b0000;
        blink_phase = 1'b1;
        frame_valid = 1'b0;
        run_until(45);
        frame_data  = 32'h0000_0000;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        run_until(50);
        #2 reset_n = 1'b0;
        #1 check_reset("mid-scan reset");
        @(posedge clk_100MHz);
        #1 check_reset("mid-scan reset held");
        reset_n = 1'b1;
        model_reset();
        repeat (FRAME + 5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
